// File: rtl/kyber_pkg.sv
// Shared Baby-Kyber definitions: ring constants, coefficient types, FSM state type
// and the modular reduction helper used by both the encrypt and decrypt paths.
package kyber_pkg;

  localparam int Q      = 17;
  localparam int N      = 4;
  localparam int K      = 2;
  localparam int Q_HALF = 9;

  typedef logic signed [31:0] coeff_t;
  typedef coeff_t [N-1:0]     poly_t;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StReduce
  } enc_state_t;

  // Canonical residue in [0,Q-1], valid for negative inputs as well.
  function automatic coeff_t mod_q(coeff_t x);
    coeff_t r;
    r = ((x % Q) + Q) % Q;
    return r;
  endfunction

endpackage

// File: rtl/kyber_coeff_mac.sv
// Registered bank of 3x4 signed accumulators with a single multiply-accumulate
// port; the product is added to or subtracted from one selected entry.
module kyber_coeff_mac
  import kyber_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           enable,
  input  logic [1:0]                     out,
  input  logic [1:0]                     idx,
  input  logic                           negate,
  input  logic signed [31:0]             op_a,
  input  logic signed [31:0]             op_b,
  output logic signed [2:0][N-1:0][31:0] acc
);

  coeff_t [2:0][N-1:0] acc_q;
  coeff_t              prod;

  // Operands are small, so the truncated 32-bit product is exact.
  assign prod = op_a * op_b;
  assign acc  = acc_q;

  // Accumulator bank: clear has priority over an accumulate step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (enable) begin
      if (negate) begin
        acc_q[out][idx] <= acc_q[out][idx] - prod;
      end else begin
        acc_q[out][idx] <= acc_q[out][idx] + prod;
      end
    end
  end

endmodule

// File: rtl/kyber_encrypt.sv
// Baby-Kyber encryption: u = A^T r + e1, v = t^T r + e2 + encode(m), computed with
// one time-multiplexed MAC over 96 cycles followed by a single reduction cycle.
module kyber_encrypt #(
  parameter int Q = 17,
  parameter int N = 4,
  parameter int K = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [N-1:0]                           message,
  input  logic signed [K-1:0][K-1:0][N-1:0][31:0] a_matrix,
  input  logic signed [K-1:0][N-1:0][31:0]        t_vec,
  input  logic signed [K-1:0][N-1:0][31:0]        r_vec,
  input  logic signed [K-1:0][N-1:0][31:0]        e1_vec,
  input  logic signed [N-1:0][31:0]               e2_poly,
  output logic signed [K-1:0][K-1:0][N-1:0][31:0] ciphertext,
  output logic                                   busy,
  output logic                                   done
);

  import kyber_pkg::*;

  // Message bit 1 maps to round(Q/2).
  localparam coeff_t Enc = coeff_t'((Q + 1) / 2);

  enc_state_t                   state_q;
  logic [6:0]                   cnt_q;
  coeff_t [K-1:0][K-1:0][N-1:0] a_q;
  coeff_t [K-1:0][N-1:0]        t_q;
  coeff_t [K-1:0][N-1:0]        r_q;
  coeff_t [K-1:0][N-1:0]        e1_q;
  coeff_t [N-1:0]               e2_q;
  logic [N-1:0]                 msg_q;
  coeff_t [K-1:0][K-1:0][N-1:0] ct_q;
  coeff_t [K-1:0][K-1:0][N-1:0] ct_next;
  logic                         busy_q;
  logic                         done_q;

  coeff_t [2:0][N-1:0]          acc;
  logic [1:0]                   sel_out;
  logic                         sel_term;
  logic [1:0]                   sel_i;
  logic [1:0]                   sel_j;
  logic [2:0]                   sum_ij;
  coeff_t                       op_a;
  coeff_t                       op_b;
  logic                         mac_clear;
  logic                         mac_enable;

  assign {sel_out, sel_term, sel_i, sel_j} = cnt_q;
  assign sum_ij     = 3'(sel_i) + 3'(sel_j);
  assign mac_clear  = (state_q == StIdle) && start;
  assign mac_enable = (state_q == StMac);

  assign ciphertext = ct_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Operand selection: rows of A^T for u0/u1, t for v; r supplies the second factor.
  always_comb begin
    op_a = '0;
    case (sel_out)
      2'd0:    op_a = a_q[sel_term][0][sel_i];
      2'd1:    op_a = a_q[sel_term][1][sel_i];
      default: op_a = t_q[sel_term][sel_i];
    endcase
    op_b = r_q[sel_term][sel_j];
  end

  // Add noise and message encoding, then fold every coefficient into [0,Q-1].
  always_comb begin
    ct_next = '0;
    for (int c = 0; c < K; c++) begin
      for (int k = 0; k < N; k++) begin
        ct_next[0][c][k] = mod_q(acc[c][k] + e1_q[c][k]);
      end
    end
    for (int k = 0; k < N; k++) begin
      ct_next[1][0][k] = mod_q(acc[2][k] + e2_q[k] + (msg_q[k] ? Enc : coeff_t'(0)));
    end
  end

  // Index wraps past x^3 subtract because x^N = -1 in the ring.
  kyber_coeff_mac u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (mac_clear),
    .enable (mac_enable),
    .out    (sel_out),
    .idx    (sum_ij[1:0]),
    .negate (sum_ij[2]),
    .op_a   (op_a),
    .op_b   (op_b),
    .acc    (acc)
  );

  // Control FSM with input capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      t_q     <= '0;
      r_q     <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
      msg_q   <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a_matrix;
            t_q     <= t_vec;
            r_q     <= r_vec;
            e1_q    <= e1_vec;
            e2_q    <= e2_poly;
            msg_q   <= message;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StMac;
          end
        end
        StMac: begin
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q == 7'd95) begin
            state_q <= StReduce;
          end
        end
        StReduce: begin
          ct_q    <= ct_next;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_encrypt.sv
// Bench for kyber_encrypt: a polynomial-level reference model plus timeline model,
// a per-cycle output comparator, directed literal cases and a randomized round trip.
module tb_kyber_encrypt;

  typedef logic [1:0][1:0][3:0][31:0] ct_t;
  typedef logic [1:0][3:0][31:0]      vec_t;
  typedef logic [3:0][31:0]           poly_t;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic                            start;
  logic [3:0]                      message;
  logic signed [1:0][1:0][3:0][31:0] a_matrix;
  logic signed [1:0][3:0][31:0]      t_vec;
  logic signed [1:0][3:0][31:0]      r_vec;
  logic signed [1:0][3:0][31:0]      e1_vec;
  logic signed [3:0][31:0]           e2_poly;
  logic signed [1:0][1:0][3:0][31:0] ciphertext;
  logic                            busy;
  logic                            done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kyber_encrypt dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .message    (message),
    .a_matrix   (a_matrix),
    .t_vec      (t_vec),
    .r_vec      (r_vec),
    .e1_vec     (e1_vec),
    .e2_poly    (e2_poly),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic int md(int x);
    return ((x % 17) + 17) % 17;
  endfunction

  // Coefficient k of a*b in Z[x]/(x^4+1).
  function automatic int nc_mul(poly_t a, poly_t b, int k);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int p;
        p = $signed(a[i]) * $signed(b[j]);
        if (i + j == k) s += p;
        else if (i + j == k + 4) s -= p;
      end
    end
    return s;
  endfunction

  // Reference ciphertext from the current input values.
  function automatic ct_t model_ct();
    ct_t ct;
    int  s;
    ct = '0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) begin
        s = $signed(e1_vec[c][k]);
        for (int tm = 0; tm < 2; tm++) s += nc_mul(a_matrix[tm][c], r_vec[tm], k);
        ct[0][c][k] = md(s);
      end
    end
    for (int k = 0; k < 4; k++) begin
      s = $signed(e2_poly[k]) + (message[k] ? 9 : 0);
      for (int tm = 0; tm < 2; tm++) s += nc_mul(t_vec[tm], r_vec[tm], k);
      ct[1][0][k] = md(s);
    end
    return ct;
  endfunction

  function automatic logic [3:0] decrypt(ct_t ct, vec_t s);
    logic [3:0] m;
    int         w;
    for (int k = 0; k < 4; k++) begin
      w = $signed(ct[1][0][k]);
      for (int c = 0; c < 2; c++) w -= nc_mul(s[c], ct[0][c], k);
      w = md(w);
      m[k] = (w >= 5) && (w <= 12);
    end
    return m;
  endfunction

  // Timeline model: 97 cycles from the sampling edge to done; start ignored while busy.
  ct_t  exp_ct;
  ct_t  pend_ct;
  logic exp_busy;
  logic exp_done;
  int   left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_ct   <= '0;
      pend_ct  <= '0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      left     <= 0;
    end else begin
      exp_done <= 1'b0;
      if (left == 0) begin
        if (start) begin
          pend_ct  <= model_ct();
          left     <= 97;
          exp_busy <= 1'b1;
        end
      end else begin
        left <= left - 1;
        if (left == 1) begin
          exp_ct   <= pend_ct;
          exp_done <= 1'b1;
          exp_busy <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison, sampled after the edge has settled.
  always @(posedge clk) begin
    #2;
    chk("busy", {511'b0, busy}, {511'b0, exp_busy});
    chk("done", {511'b0, done}, {511'b0, exp_done});
    chk("ciphertext", ciphertext, exp_ct);
  end

  task automatic clear_inputs();
    start    = 1'b0;
    message  = '0;
    a_matrix = '0;
    t_vec    = '0;
    r_vec    = '0;
    e1_vec   = '0;
    e2_poly  = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges until done, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #2;
    end while (!done && lat < 300);
    chk("done_seen", {511'b0, done}, 512'd1);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clk);
      #2;
      if (done) n++;
    end
  endtask

  task automatic run_lit(input string nm, input ct_t lit);
    int lat;
    pulse_start();
    wait_done(lat);
    chk({nm, "_latency"}, 512'(lat), 512'd97);
    chk({nm, "_ct"}, ciphertext, lit);
    @(posedge clk);
    #2;
    chk({nm, "_done_width"}, {511'b0, done}, 512'd0);
  endtask

  initial begin
    ct_t        lit;
    vec_t       s_key;
    int         lat;
    int         n;
    int         acc;
    int         pos;
    logic [3:0] m_rec;

    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("reset_ct", ciphertext, 512'd0);
    chk("reset_busy", {511'b0, busy}, 512'd0);
    chk("reset_done", {511'b0, done}, 512'd0);

    // Message-only encoding.
    clear_inputs();
    message = 4'b1010;
    lit = '0;
    lit[1][0][1] = 32'd9;
    lit[1][0][3] = 32'd9;
    run_lit("msg_only", lit);

    // x^3 * x = x^4 = -1.
    clear_inputs();
    t_vec[0][3] = 32'sd1;
    r_vec[0][1] = 32'sd1;
    lit = '0;
    lit[1][0][0] = 32'd16;
    run_lit("wrap", lit);

    // A[1][0] contributes to u0 through the transpose.
    clear_inputs();
    a_matrix[1][0][0] = 32'sd1;
    r_vec[1][1] = 32'sd1;
    lit = '0;
    lit[0][0][1] = 32'd1;
    run_lit("transpose", lit);

    // Negative noise reduces into range.
    clear_inputs();
    e1_vec[1][2] = -32'sd2;
    e2_poly[3]   = -32'sd1;
    lit = '0;
    lit[0][1][2] = 32'd15;
    lit[1][0][3] = 32'd16;
    run_lit("neg_noise", lit);

    // Start during MAC is ignored; result reflects the first capture.
    clear_inputs();
    t_vec[0][3] = 32'sd1;
    r_vec[0][1] = 32'sd1;
    pulse_start();
    repeat (10) @(posedge clk);
    clear_inputs();
    message = 4'b1111;
    e2_poly[0] = 32'sd2;
    pulse_start();
    wait_done(lat);
    chk("busy_start_latency", 512'(lat), 512'd86);
    lit = '0;
    lit[1][0][0] = 32'd16;
    chk("busy_start_ct", ciphertext, lit);
    count_dones(110, n);
    chk("busy_start_no_queue", 512'(n), 512'd0);

    // Reset mid-operation aborts without done.
    clear_inputs();
    message = 4'b0101;
    pulse_start();
    repeat (49) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("abort_ct", ciphertext, 512'd0);
    chk("abort_busy", {511'b0, busy}, 512'd0);
    chk("abort_done", {511'b0, done}, 512'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_dones(110, n);
    chk("abort_no_done", 512'(n), 512'd0);
    clear_inputs();
    a_matrix[1][0][0] = 32'sd1;
    r_vec[1][1] = 32'sd1;
    lit = '0;
    lit[0][0][1] = 32'd1;
    run_lit("after_abort", lit);

    // Back-to-back: start held through the done cycle is taken at the next edge.
    clear_inputs();
    message = 4'b0011;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 message = 4'b1100;
    wait_done(lat);
    chk("b2b_first_latency", 512'(lat), 512'd97);
    @(posedge clk);
    #1 start = 1'b0;
    #1;
    chk("b2b_busy", {511'b0, busy}, 512'd1);
    wait_done(lat);
    chk("b2b_second_latency", 512'(lat), 512'd97);
    lit = '0;
    lit[1][0][2] = 32'd9;
    lit[1][0][3] = 32'd9;
    chk("b2b_second_ct", ciphertext, lit);

    // Randomized round trip with keys t = A*s + e and small noise.
    for (int trial = 0; trial < 200; trial++) begin
      clear_inputs();
      for (int rw = 0; rw < 2; rw++)
        for (int c = 0; c < 2; c++)
          for (int k = 0; k < 4; k++) a_matrix[rw][c][k] = $urandom_range(0, 16);
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 4; k++) begin
          s_key[c][k] = int'($urandom_range(0, 2)) - 1;
          r_vec[c][k] = int'($urandom_range(0, 2)) - 1;
        end
      pos = $urandom_range(0, 7);
      for (int rw = 0; rw < 2; rw++)
        for (int k = 0; k < 4; k++) begin
          acc = (rw * 4 + k == pos) ? (($urandom_range(0, 1) == 1) ? 1 : -1) : 0;
          for (int c = 0; c < 2; c++) acc += nc_mul(a_matrix[rw][c], s_key[c], k);
          t_vec[rw][k] = md(acc);
        end
      pos = $urandom_range(0, 7);
      e1_vec[pos / 4][pos % 4] = ($urandom_range(0, 1) == 1) ? 32'sd1 : -32'sd1;
      for (int k = 0; k < 4; k++) e2_poly[k] = int'($urandom_range(0, 2)) - 1;
      message = 4'($urandom_range(0, 15));
      lit = model_ct();
      pulse_start();
      wait_done(lat);
      chk("rand_ct", ciphertext, lit);
      m_rec = decrypt(ciphertext, s_key);
      chk("round_trip", {508'b0, m_rec}, {508'b0, message});
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
